// File: rtl/control_sequencer_pkg.sv
// Shared CPU control definitions: opcodes, IR field positions, sequencer states
// and the opcode classifier used by the hardwired control unit.
package cpu_defs;
   localparam int ALU_W     = 5;
   localparam int REG_IDX_W = 4;

   localparam int OP_HI = 31;
   localparam int OP_LO = 27;
   localparam int RA_HI = 26;
   localparam int RA_LO = 23;
   localparam int RB_HI = 22;
   localparam int RB_LO = 19;
   localparam int RC_HI = 18;
   localparam int RC_LO = 15;

   localparam logic [ALU_W-1:0] OP_ADD = 5'b00011;
   localparam logic [ALU_W-1:0] OP_SUB = 5'b00100;
   localparam logic [ALU_W-1:0] OP_AND = 5'b00101;
   localparam logic [ALU_W-1:0] OP_OR  = 5'b00110;
   localparam logic [ALU_W-1:0] OP_SHR = 5'b00111;
   localparam logic [ALU_W-1:0] OP_SHL = 5'b01000;
   localparam logic [ALU_W-1:0] OP_ROR = 5'b01001;
   localparam logic [ALU_W-1:0] OP_ROL = 5'b01010;
   localparam logic [ALU_W-1:0] OP_MUL = 5'b01111;
   localparam logic [ALU_W-1:0] OP_DIV = 5'b10000;
   localparam logic [ALU_W-1:0] OP_NEG = 5'b10001;
   localparam logic [ALU_W-1:0] OP_NOT = 5'b10010;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_T7   = 4'd8,
      S_HALT = 4'd9
   } state_t;

   typedef enum logic [1:0] {
      CLS_ALU3    = 2'd0,
      CLS_MULDIV  = 2'd1,
      CLS_UNARY   = 2'd2,
      CLS_ILLEGAL = 2'd3
   } op_class_t;

   function automatic op_class_t classify(input logic [ALU_W-1:0] op);
      op_class_t cls;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_ALU3;
         OP_MUL, OP_DIV:                 cls = CLS_MULDIV;
         OP_NEG, OP_NOT:                 cls = CLS_UNARY;
         default:                        cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction
endpackage

// File: rtl/control_sequencer_reg_select_decode.sv
// Register index to one-hot select decoder, used for the Rin and Rout buses.
module reg_select_decode
   import cpu_defs::*;
#(
   parameter int N = 16
) (
   input  logic [REG_IDX_W-1:0] i_idx,
   input  logic                 i_en,
   output logic [N-1:0]         o_sel
);

   // one-hot decode of the register index, all zero when disabled
   always_comb begin
      o_sel = '0;
      if (i_en) begin
         o_sel[i_idx] = 1'b1;
      end else begin
         o_sel = '0;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the phase-1 CPU datapath.
// Strobes are Moore outputs decoded from the registered state and the IR fields.
module control_sequencer
   import cpu_defs::*;
#(
   parameter int NUM_REGS = 16
) (
   input  logic                Clock,
   input  logic                Resetn,
   input  logic                Run,
   input  logic                MemReady,
   input  logic [31:0]         IR,
   output logic                PCout,
   output logic                ZLOout,
   output logic                ZHIout,
   output logic                MDRout,
   output logic                PCin,
   output logic                MARin,
   output logic                MDRin,
   output logic                IRin,
   output logic                Yin,
   output logic                Zin,
   output logic                HIin,
   output logic                LOin,
   output logic                IncrementPC,
   output logic                Read,
   output logic [NUM_REGS-1:0] Rin,
   output logic [NUM_REGS-1:0] Rout,
   output logic [ALU_W-1:0]    ALUControl,
   output logic                Done,
   output logic                Illegal
);

   state_t                 r_state;
   state_t                 w_next;
   state_t                 w_after;
   logic                   r_illegal;
   logic [ALU_W-1:0]       w_op;
   logic [REG_IDX_W-1:0]   w_ra;
   logic [REG_IDX_W-1:0]   w_rb;
   logic [REG_IDX_W-1:0]   w_rc;
   logic [REG_IDX_W-1:0]   w_rout_idx;
   logic                   w_rin_en;
   logic                   w_rout_en;
   op_class_t              w_cls;
   logic                   w_unused_ir;

   assign w_op        = IR[OP_HI:OP_LO];
   assign w_ra        = IR[RA_HI:RA_LO];
   assign w_rb        = IR[RB_HI:RB_LO];
   assign w_rc        = IR[RC_HI:RC_LO];
   assign w_cls       = classify(w_op);
   assign w_unused_ir = &{1'b0, IR[RC_LO-1:0]};
   assign Illegal     = r_illegal;

   // state register and sticky illegal flag, synchronous active-low reset
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         r_state   <= S_IDLE;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_T3 && w_cls == CLS_ILLEGAL) begin
            r_illegal <= 1'b1;
         end else begin
            r_illegal <= r_illegal;
         end
      end
   end

   // next-state: the instruction length depends on the opcode class
   always_comb begin
      w_after = Run ? S_T0 : S_IDLE;
      w_next  = r_state;
      case (r_state)
         S_IDLE: w_next = Run ? S_T0 : S_IDLE;
         S_T0:   w_next = S_T1;
         S_T1:   w_next = S_T2;
         S_T2:   w_next = MemReady ? S_T3 : S_T2;
         S_T3:   w_next = (w_cls == CLS_ILLEGAL) ? S_HALT : S_T4;
         S_T4:   w_next = S_T5;
         S_T5:   w_next = (w_cls == CLS_UNARY) ? w_after : S_T6;
         S_T6:   w_next = (w_cls == CLS_MULDIV) ? S_T7 : w_after;
         S_T7:   w_next = w_after;
         S_HALT: w_next = S_HALT;
         default: w_next = S_IDLE;
      endcase
   end

   // per-state strobe decode; only one bus driver is ever asserted
   always_comb begin
      PCout       = 1'b0;
      ZLOout      = 1'b0;
      ZHIout      = 1'b0;
      MDRout      = 1'b0;
      PCin        = 1'b0;
      MARin       = 1'b0;
      MDRin       = 1'b0;
      IRin        = 1'b0;
      Yin         = 1'b0;
      Zin         = 1'b0;
      HIin        = 1'b0;
      LOin        = 1'b0;
      IncrementPC = 1'b0;
      Read        = 1'b0;
      Done        = 1'b0;
      ALUControl  = 5'b00000;
      w_rin_en    = 1'b0;
      w_rout_en   = 1'b0;
      w_rout_idx  = w_rb;
      case (r_state)
         S_T0: begin
            PCout       = 1'b1;
            MARin       = 1'b1;
            IncrementPC = 1'b1;
            Zin         = 1'b1;
         end
         S_T1: begin
            ZLOout = 1'b1;
            PCin   = 1'b1;
         end
         S_T2: begin
            Read  = 1'b1;
            MDRin = 1'b1;
         end
         S_T3: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T4: begin
            w_rout_en = 1'b1;
            if (w_cls == CLS_UNARY) begin
               ALUControl = w_op;
               Zin        = 1'b1;
            end else begin
               Yin = 1'b1;
            end
         end
         S_T5: begin
            if (w_cls == CLS_UNARY) begin
               ZLOout   = 1'b1;
               w_rin_en = 1'b1;
               Done     = 1'b1;
            end else begin
               w_rout_en  = 1'b1;
               w_rout_idx = w_rc;
               ALUControl = w_op;
               Zin        = 1'b1;
            end
         end
         S_T6: begin
            ZLOout = 1'b1;
            if (w_cls == CLS_MULDIV) begin
               LOin = 1'b1;
            end else begin
               w_rin_en = 1'b1;
               Done     = 1'b1;
            end
         end
         S_T7: begin
            ZHIout = 1'b1;
            HIin   = 1'b1;
            Done   = 1'b1;
         end
         default: begin
            Done = 1'b0;
         end
      endcase
   end

   reg_select_decode #(.N(NUM_REGS)) u_rin_dec (
      .i_idx (w_ra),
      .i_en  (w_rin_en),
      .o_sel (Rin)
   );

   reg_select_decode #(.N(NUM_REGS)) u_rout_dec (
      .i_idx (w_rout_idx),
      .i_en  (w_rout_en),
      .o_sel (Rout)
   );

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised bench for control_sequencer: an instruction-level step model is
// compared with the DUT every cycle, plus directed literal checks.
module tb_control_sequencer;

   localparam int B_PCOUT  = 52;
   localparam int B_ZLOOUT = 51;
   localparam int B_ZHIOUT = 50;
   localparam int B_MDROUT = 49;
   localparam int B_PCIN   = 48;
   localparam int B_MARIN  = 47;
   localparam int B_MDRIN  = 46;
   localparam int B_IRIN   = 45;
   localparam int B_YIN    = 44;
   localparam int B_ZIN    = 43;
   localparam int B_HIIN   = 42;
   localparam int B_LOIN   = 41;
   localparam int B_INCPC  = 40;
   localparam int B_READ   = 39;
   localparam int B_DONE   = 38;
   localparam int B_ILL    = 37;

   localparam int M_IDLE = 0;
   localparam int M_BUSY = 1;
   localparam int M_HALT = 2;

   logic        clk = 1'b0;
   logic        Resetn = 1'b0;
   logic        Run = 1'b0;
   logic        MemReady = 1'b1;
   logic [31:0] IR = 32'h0;
   logic        PCout, ZLOout, ZHIout, MDRout, PCin, MARin, MDRin, IRin;
   logic        Yin, Zin, HIin, LOin, IncrementPC, Read, Done, Illegal;
   logic [15:0] Rin, Rout;
   logic [4:0]  ALUControl;
   logic [52:0] dut_vec;

   int          n_checks = 0;
   int          n_err = 0;
   bit          chk_en = 1'b0;
   int          m_mode = M_IDLE;
   int          m_k = 0;
   bit          m_ill = 1'b0;
   logic [52:0] snap [0:63];
   int          lat;

   always #5 clk = ~clk;

   control_sequencer #(.NUM_REGS(16)) dut (
      .Clock(clk), .Resetn(Resetn), .Run(Run), .MemReady(MemReady), .IR(IR),
      .PCout(PCout), .ZLOout(ZLOout), .ZHIout(ZHIout), .MDRout(MDRout),
      .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .Zin(Zin), .HIin(HIin), .LOin(LOin), .IncrementPC(IncrementPC),
      .Read(Read), .Rin(Rin), .Rout(Rout), .ALUControl(ALUControl),
      .Done(Done), .Illegal(Illegal)
   );

   assign dut_vec = {PCout, ZLOout, ZHIout, MDRout, PCin, MARin, MDRin, IRin,
                     Yin, Zin, HIin, LOin, IncrementPC, Read, Done, Illegal,
                     ALUControl, Rin, Rout};

   // 0 illegal, 1 three-register ALU, 2 mul/div, 3 unary
   function automatic int cls_of(input logic [4:0] op);
      if (op >= 5'd3 && op <= 5'd10) return 1;
      else if (op == 5'd15 || op == 5'd16) return 2;
      else if (op == 5'd17 || op == 5'd18) return 3;
      else return 0;
   endfunction

   function automatic int n_steps(input int cls);
      if (cls == 3) return 6;
      else if (cls == 2) return 8;
      else return 7;
   endfunction

   // strobes expected in step k of an instruction (steps 0..3 are the fetch)
   function automatic logic [52:0] exp_vec(input int mode, input int k, input bit ill,
                                           input logic [31:0] ir);
      logic [52:0] v;
      logic [4:0]  op;
      int          ra, rb, rc, cls;
      v = '0;
      v[B_ILL] = ill;
      op  = ir[31:27];
      ra  = int'(ir[26:23]);
      rb  = int'(ir[22:19]);
      rc  = int'(ir[18:15]);
      cls = cls_of(op);
      if (mode == M_BUSY) begin
         if (k == 0) begin
            v[B_PCOUT] = 1'b1; v[B_MARIN] = 1'b1; v[B_INCPC] = 1'b1; v[B_ZIN] = 1'b1;
         end else if (k == 1) begin
            v[B_ZLOOUT] = 1'b1; v[B_PCIN] = 1'b1;
         end else if (k == 2) begin
            v[B_READ] = 1'b1; v[B_MDRIN] = 1'b1;
         end else if (k == 3) begin
            v[B_MDROUT] = 1'b1; v[B_IRIN] = 1'b1;
         end else if (cls == 3) begin
            if (k == 4) begin
               v[rb] = 1'b1; v[36:32] = op; v[B_ZIN] = 1'b1;
            end else begin
               v[B_ZLOOUT] = 1'b1; v[16 + ra] = 1'b1; v[B_DONE] = 1'b1;
            end
         end else if (k == 4) begin
            v[rb] = 1'b1; v[B_YIN] = 1'b1;
         end else if (k == 5) begin
            v[rc] = 1'b1; v[36:32] = op; v[B_ZIN] = 1'b1;
         end else if (k == 6 && cls == 2) begin
            v[B_ZLOOUT] = 1'b1; v[B_LOIN] = 1'b1;
         end else if (k == 6) begin
            v[B_ZLOOUT] = 1'b1; v[16 + ra] = 1'b1; v[B_DONE] = 1'b1;
         end else begin
            v[B_ZHIOUT] = 1'b1; v[B_HIIN] = 1'b1; v[B_DONE] = 1'b1;
         end
      end
      return v;
   endfunction

   // reference model: advance one step per edge
   always @(posedge clk) begin
      if (!Resetn) begin
         m_mode <= M_IDLE; m_k <= 0; m_ill <= 1'b0;
      end else if (m_mode == M_IDLE) begin
         if (Run) begin m_mode <= M_BUSY; m_k <= 0; end
      end else if (m_mode == M_BUSY) begin
         if (m_k == 2 && !MemReady) begin
            m_k <= 2;
         end else if (m_k == 3 && cls_of(IR[31:27]) == 0) begin
            m_mode <= M_HALT; m_ill <= 1'b1;
         end else if (m_k == n_steps(cls_of(IR[31:27])) - 1) begin
            if (Run) m_k <= 0;
            else m_mode <= M_IDLE;
         end else begin
            m_k <= m_k + 1;
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         logic [52:0] e;
         e = exp_vec(m_mode, m_k, m_ill, IR);
         n_checks++;
         if (dut_vec !== e) begin
            n_err++;
            $display("FAIL model_cmp t=%0t: dut=0x%0h model=0x%0h", $time, dut_vec, e);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // issue one instruction from IDLE and record ncyc cycles of outputs
   task automatic run_instr(input logic [31:0] ir, input int stall, input bit keep_run,
                            input int rst_at, input int ncyc);
      lat = 0;
      IR = ir; Run = 1'b1; MemReady = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk); #1;
         if (!keep_run) Run = 1'b0;
         MemReady = (c >= 3 && c < 3 + stall) ? 1'b0 : 1'b1;
         Resetn   = (rst_at != 0 && c == rst_at) ? 1'b0 : 1'b1;
         @(negedge clk);
         snap[c] = dut_vec;
         if (dut_vec[B_DONE] && lat == 0) lat = c;
      end
   endtask

   initial begin
      logic [52:0] mv;
      logic        acc;
      logic [4:0]  legal_ops [0:11];
      legal_ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                    5'd15, 5'd16, 5'd17, 5'd18};

      mv = exp_vec(M_BUSY, 5, 1'b0, 32'h1AB38000);
      chk("model_add_T5", 64'(mv), 64'h0000_0803_0000_0080);
      mv = exp_vec(M_BUSY, 7, 1'b0, 32'h781A0000);
      chk("model_mul_T7", 64'(mv), 64'h0004_0440_0000_0000);

      ticks(3);
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset_outputs", 64'(dut_vec), 64'd0);
      ticks(1);
      Resetn = 1'b1;
      ticks(1);

      run_instr(32'h1AB38000, 0, 1'b0, 0, 7);
      chk("add_latency", 64'(lat), 64'd7);
      chk("add_T0", 64'({snap[1][B_PCOUT], snap[1][B_MARIN], snap[1][B_INCPC], snap[1][B_ZIN], snap[1][36:32]}), 64'h1E0);
      chk("add_T4_rout", 64'(snap[5][15:0]), 64'h0040);
      chk("add_T4_yin", 64'(snap[5][B_YIN]), 64'd1);
      chk("add_T5_rout", 64'(snap[6][15:0]), 64'h0080);
      chk("add_T5_alu", 64'(snap[6][36:32]), 64'd3);
      chk("add_T5_zin", 64'(snap[6][B_ZIN]), 64'd1);
      chk("add_T6_rin", 64'(snap[7][31:16]), 64'h0020);
      chk("add_T6_zlo_done", 64'({snap[7][B_ZLOOUT], snap[7][B_DONE]}), 64'd3);
      ticks(3);

      run_instr(32'h92100000, 0, 1'b0, 0, 6);
      chk("not_latency", 64'(lat), 64'd6);
      chk("not_T4_rout", 64'(snap[5][15:0]), 64'h0004);
      chk("not_T4_alu", 64'(snap[5][36:32]), 64'h12);
      chk("not_T4_zin", 64'(snap[5][B_ZIN]), 64'd1);
      chk("not_T5_rin", 64'(snap[6][31:16]), 64'h0010);
      acc = 1'b0;
      for (int c = 1; c <= 6; c++) acc = acc | snap[c][B_YIN];
      chk("not_no_yin", 64'(acc), 64'd0);
      ticks(3);

      run_instr(32'h781A0000, 0, 1'b0, 0, 8);
      chk("mul_latency", 64'(lat), 64'd8);
      chk("mul_T6", 64'({snap[7][B_LOIN], snap[7][B_ZLOOUT], snap[7][B_DONE]}), 64'd6);
      chk("mul_T7", 64'({snap[8][B_HIIN], snap[8][B_ZHIOUT], snap[8][B_DONE]}), 64'd7);
      acc = 1'b0;
      for (int c = 1; c <= 8; c++) acc = acc | (|snap[c][31:16]);
      chk("mul_no_rin", 64'(acc), 64'd0);
      ticks(3);

      run_instr(32'h1AB38000, 3, 1'b1, 0, 11);
      chk("stall_latency", 64'(lat), 64'd10);
      for (int c = 3; c <= 6; c++)
         chk($sformatf("stall_read_c%0d", c), 64'({snap[c][B_READ], snap[c][B_MDRIN]}), 64'd3);
      chk("stall_T3", 64'({snap[7][B_READ], snap[7][B_IRIN]}), 64'd1);
      chk("b2b_T0", 64'({snap[11][B_PCOUT], snap[11][B_MARIN]}), 64'd3);
      ticks(1);
      Run = 1'b0;
      ticks(12);

      run_instr(32'h1AB38000, 0, 1'b0, 6, 9);
      chk("rst_in_T5", 64'(snap[6][B_ZIN]), 64'd1);
      chk("rst_outputs", 64'(snap[7]), 64'd0);
      chk("rst_idle", 64'(snap[9]), 64'd0);
      chk("rst_no_done", 64'(lat), 64'd0);
      ticks(3);

      run_instr(32'hF8000000, 0, 1'b1, 0, 20);
      chk("ill_T3", 64'({snap[4][B_IRIN], snap[4][B_ILL]}), 64'd2);
      chk("ill_halt", 64'(snap[5]), 64'h0000_0020_0000_0000);
      chk("ill_hold", 64'(snap[20]), 64'h0000_0020_0000_0000);
      chk("ill_no_done", 64'(lat), 64'd0);
      ticks(1);
      Run = 1'b0; Resetn = 1'b0;
      ticks(1);
      Resetn = 1'b1;
      @(negedge clk);
      chk("ill_cleared", 64'(dut_vec[B_ILL]), 64'd0);
      ticks(1);

      // random phase; IR only changes while the current instruction does not use it
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         Run      = ($urandom_range(0, 9) < 7);
         MemReady = ($urandom_range(0, 3) != 0);
         if (m_mode == M_HALT) Resetn = ($urandom_range(0, 9) != 0);
         else                  Resetn = ($urandom_range(0, 99) != 0);
         if (m_mode != M_BUSY || m_k <= 2) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 9) == 0) r[31:27] = 5'($urandom_range(0, 31));
            else r[31:27] = legal_ops[$urandom_range(0, 11)];
            IR = r;
         end
      end
      ticks(2);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
